// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, state and width constants for the RISC CPU control path
package cpu_pkg;
    localparam int OP_W   = 3;
    localparam int ADDR_W = 13;

    localparam logic [OP_W-1:0] OP_HLT = 3'b000;
    localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDA = 3'b101;
    localparam logic [OP_W-1:0] OP_STO = 3'b110;
    localparam logic [OP_W-1:0] OP_JMP = 3'b111;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_T0     = 4'd1;
    localparam logic [3:0] ST_T1     = 4'd2;
    localparam logic [3:0] ST_T2     = 4'd3;
    localparam logic [3:0] ST_T3     = 4'd4;
    localparam logic [3:0] ST_T4     = 4'd5;
    localparam logic [3:0] ST_T5     = 4'd6;
    localparam logic [3:0] ST_T6     = 4'd7;
    localparam logic [3:0] ST_T7     = 4'd8;
    localparam logic [3:0] ST_HALTED = 4'd9;

    // Opcodes that read a memory operand and load the accumulator
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_LDA;
    endfunction
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase fetch/decode/execute control FSM of the 8-bit-bus RISC CPU
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            load_ir,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_acc,
    output logic            rd,
    output logic            wr,
    output logic            datactl_ena,
    output logic            addr_sel,
    output logic            halt,
    output logic [3:0]      phase
);
    logic [3:0] state, state_nxt;
    logic       fetch, t4, t5, t6, alu, sto, jmp, skz;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= ST_IDLE;
        else if (ena)
            state <= state_nxt;

    // Unused codes (10..15) fall back to IDLE
    always_comb begin
        state_nxt = (state == ST_HALTED) ? ST_HALTED :
                    (state == ST_T3)     ? ((opcode == OP_HLT) ? ST_HALTED : ST_T4) :
                    (state == ST_T7)     ? ST_T0 :
                    (state <= ST_T6)     ? state + 4'd1 : ST_IDLE;
    end

    always_comb begin
        fetch       = state == ST_T0 || state == ST_T1;
        t4          = state == ST_T4;
        t5          = state == ST_T5;
        t6          = state == ST_T6;
        alu         = is_alu_op(opcode);
        sto         = opcode == OP_STO;
        jmp         = opcode == OP_JMP;
        skz         = opcode == OP_SKZ;
        load_ir     = ena && fetch;
        inc_pc      = ena && (fetch || (skz && zero && (t5 || t6)));
        load_pc     = ena && jmp && (t4 || t5);
        load_acc    = ena && alu && t5;
        rd          = ena && (fetch || (alu && (t4 || t5)));
        wr          = ena && sto && t5;
        datactl_ena = ena && sto && (t4 || t5 || t6);
        addr_sel    = ena && ((alu && (t4 || t5)) || (sto && (t4 || t5 || t6)));
        halt        = state == ST_HALTED;
        phase       = state;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Main control state machine of the 8-bit-bus RISC CPU.
- Sequences each 16-bit instruction as an 8-phase cycle: a two-byte fetch into the instruction register (load_ir pulsed twice: first byte to instr[7:0], second to instr[15:8]), decode, then an execute phase driven by opcode instr[15:13].
- Drives the program counter, accumulator, memory rd/wr, data-bus driver and address mux select.

Parameters:
- OP_W, 3, opcode width. Fixed; the encoding below depends on it.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ena  in  1  run enable from the clock-generation block; low freezes the sequencer
- opcode  in  3  instr[15:13] from the instruction register; sampled T2..T7 only
- zero  in  1  accumulator == 0 flag
- load_ir  out  1  IR byte load strobe
- inc_pc  out  1  PC += 1
- load_pc  out  1  PC <= instr[12:0]
- load_acc  out  1  accumulator load (ALU result)
- rd  out  1  memory read
- wr  out  1  memory write
- datactl_ena  out  1  drive ALU output onto data bus
- addr_sel  out  1  0 = PC address, 1 = instr[12:0]
- halt  out  1  CPU halted
- phase  out  4  current state encoding (debug)

Behaviour:
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- States: IDLE=0, T0..T7=1..8, HALTED=9; 4-bit register, other codes go to IDLE.
- Reset (rst low, async): state=IDLE. All outputs 0, including halt. phase=0.
- State advances only on a clk edge with ena=1. With ena=0 the state holds and all strobes except halt are forced 0 combinationally.
- Transitions:
  - IDLE->T0; Tn->Tn+1; T7->T0.
  - T3->HALTED if opcode==HLT, else T4.
  - HALTED is terminal; only rst exits it.
- Outputs are combinational from state, opcode, zero and ena. All strobes are 0 unless listed below:
  - T0: rd, load_ir, inc_pc, addr_sel=0.
  - T1: rd, load_ir, inc_pc, addr_sel=0.
  - T2: none (IR settles; opcode valid from here).
  - T3: none; exit to HALTED decided on the edge.
  - T4:
    - ADD/AND/XOR/LDA: rd, addr_sel=1.
    - STO: datactl_ena, addr_sel=1.
    - JMP: load_pc.
    - SKZ: none.
  - T5:
    - ADD/AND/XOR/LDA: rd, load_acc, addr_sel=1.
    - STO: datactl_ena, wr, addr_sel=1.
    - JMP: load_pc.
    - SKZ with zero=1: inc_pc.
  - T6:
    - STO: datactl_ena, addr_sel=1 (data hold after wr).
    - SKZ with zero=1: inc_pc. zero is sampled live each phase.
  - T7: none.
  - HALTED: halt=1, everything else 0, regardless of ena.
- Guarantees:
  - Exactly two load_ir pulses per instruction, so the IR byte toggle stays aligned.
  - Reset mid-instruction resets both blocks together.
- Latency: 8 enabled clocks per instruction. The first fetch occurs on the 2nd enabled clock after reset release (IDLE costs 1).
- SKZ skip = two inc_pc pulses (one 2-byte instruction).
- wr and rd are never high together. load_pc and inc_pc are never high together.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OP_HLT..OP_JMP), state codes (ST_IDLE, ST_T0..ST_T7, ST_HALTED), OP_W, address width 13.
- Single module; no sub-module needed. The next-state logic and the output decode are two always blocks within it.

Test Plan:
- Reset release, ena=1, opcode=LDA (101) -> IDLE then T0, T1 with rd=load_ir=inc_pc=1; T4 rd, addr_sel=1; T5 rd=load_acc=1; back to T0 after 8 clocks.
- opcode=STO (110) -> datactl_ena=1 in T4–T6, wr=1 only in T5, addr_sel=1 in T4–T6, rd=0 throughout T4–T7.
- opcode=SKZ, zero=1 -> inc_pc high in T5 and T6 (4 inc_pc pulses per instruction in total). With zero=0 -> only the 2 fetch pulses.
- opcode=JMP -> load_pc=1 in T4 and T5, inc_pc=0 in those phases.
- opcode=HLT -> T3 to HALTED; halt=1 held for 20+ clocks with all strobes 0; toggling ena has no effect; rst low clears halt asynchronously.
- ena dropped for 3 clocks during T1 -> phase stays T1 and all strobes are 0. On ena=1, load_ir is reasserted once, then T2. Async rst during T5 -> outputs 0 immediately and phase=0.
